// File: rtl/cpu_types_pkg.sv
// Shared CPU type package: word type plus instruction-cache types and geometry.
package cpu_types_pkg;

   localparam int unsigned WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;

   // Default number of instruction-cache frames
   localparam int unsigned ICACHE_SETS = 16;

   typedef enum logic {
      LOOKUP,
      FILL
   } icache_state_t;

   // Tag field is sized for the widest tag any legal geometry (SETS >= 2) needs;
   // narrower tags are stored zero-extended.
   typedef struct packed {
      logic                  valid;
      logic [WORD_BITS-3:0]  tag;
      word_t                 data;
   } icache_frame_t;

endpackage

// File: rtl/icache_frames.sv
// Instruction-cache frame array: combinational read port, synchronous write port,
// synchronous clear of every valid bit on RST. Tag/data are not reset.
module icache_frames
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = ICACHE_SETS
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [$clog2(SETS)-1:0] rd_idx,
   output icache_frame_t           rd_frame,
   input  logic                    wr_en,
   input  logic [$clog2(SETS)-1:0] wr_idx,
   input  icache_frame_t           wr_frame
);

   icache_frame_t frames_q [SETS];

   assign rd_frame = frames_q[rd_idx];

   // Reset clears only the valid bits; otherwise a completed fill writes one frame
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SETS; i++) begin
            frames_q[i].valid <= 1'b0;
         end
      end else if (wr_en) begin
         frames_q[wr_idx] <= wr_frame;
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are combinational; a miss
// fetches one word from memory control and fills one frame.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_direct
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS   = ICACHE_SETS,
   parameter int unsigned WORD_W = WORD_BITS
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              halt,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(SETS);

   icache_state_t     state_q, state_d;
   logic [WORD_W-3:0] miss_word_q;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-3:0] tag_ext;
   icache_frame_t     rd_frame, wr_frame;
   logic              hit, start_fill, fill_done;
   logic              unused_byte;

   assign idx         = imemaddr[IDX_W+1:2];
   assign tag_ext     = {{IDX_W{1'b0}}, imemaddr[WORD_W-1:IDX_W+2]};
   assign hit         = imemREN & ~halt & rd_frame.valid & (rd_frame.tag == tag_ext);
   assign unused_byte = ^imemaddr[1:0];

   icache_frames #(
      .SETS (SETS)
   ) u_frames (
      .CLK      (CLK),
      .RST      (RST),
      .rd_idx   (idx),
      .rd_frame (rd_frame),
      .wr_en    (fill_done),
      .wr_idx   (miss_word_q[IDX_W-1:0]),
      .wr_frame (wr_frame)
   );

   // Frame written at fill completion, addressed by the captured miss address
   always_comb begin
      wr_frame.valid = 1'b1;
      wr_frame.tag   = {{IDX_W{1'b0}}, miss_word_q[WORD_W-3:IDX_W]};
      wr_frame.data  = iload;
   end

   // Next state and outputs; RST forces every output to zero
   always_comb begin
      state_d    = state_q;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = '0;
      start_fill = 1'b0;
      fill_done  = 1'b0;
      case (state_q)
         LOOKUP: begin
            ihit = hit;
            if (hit) begin
               imemload = rd_frame.data;
            end
            if (imemREN && !halt && !hit) begin
               state_d    = FILL;
               start_fill = 1'b1;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = {miss_word_q, 2'b00};
            // Halt aborts without a frame write, even if memory is ready
            if (halt) begin
               state_d = LOOKUP;
            end else if (!iwait) begin
               state_d   = LOOKUP;
               fill_done = 1'b1;
            end
         end
         default: state_d = LOOKUP;
      endcase
      if (RST) begin
         state_d    = LOOKUP;
         ihit       = 1'b0;
         imemload   = '0;
         iREN       = 1'b0;
         iaddr      = '0;
         start_fill = 1'b0;
         fill_done  = 1'b0;
      end
   end

   // State register and miss-address capture on entry to FILL
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= LOOKUP;
         miss_word_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_fill) begin
            miss_word_q <= imemaddr[WORD_W-1:2];
         end
      end
   end

`ifdef ICACHE_STATS_EN
   // Saturating hit/miss counters; an aborted fill was already counted on entry
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && hit_count != 32'hFFFF_FFFF) begin
            hit_count <= hit_count + 32'd1;
         end
         if (start_fill && miss_count != 32'hFFFF_FFFF) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache directly downstream of the datapath's instruction-fetch port.
- Consumes the datapath's fetch request (imemREN/imemaddr) and returns imemload with ihit.
- On a miss, issues a single-word read to memory control and fills one frame.
- Hit path is combinational, so a hit returns the instruction in the same cycle as the request.

Parameters:
- SETS, 16, number of frames (power of two, ≥2); IDX_W = log2(SETS).
- WORD_W, 32, instruction/address width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- halt  in  1  datapath halted; suppresses hits and memory requests.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  WORD_W  fetch byte address; bits [1:0] ignored.
- ihit  out  1  imemload valid this cycle.
- imemload  out  WORD_W  fetched instruction.
- iREN  out  1  read request to memory control.
- iaddr  out  WORD_W  word-aligned memory read address.
- iwait  in  1  memory busy; iload valid in the cycle iwait is low while iREN is high.
- iload  in  WORD_W  memory read data.

Behaviour:
- Reset and synchronicity:
  - One clock (CLK).
  - Reset is synchronous and active-high (RST); sampled only on the CLK rising edge.
- Address split:
  - idx = imemaddr[IDX_W+1:2].
  - tag = imemaddr[WORD_W-1:IDX_W+2].
- Frame storage:
  - Each frame holds valid (1), tag (WORD_W-2-IDX_W) and data (WORD_W).
- FSM states:
  - LOOKUP: ihit = imemREN & !halt & valid[idx] & (tag[idx]==tag). imemload = data[idx] when ihit, else 0. iREN = 0.
  - LOOKUP -> FILL: when imemREN & !halt & !hit. On that edge, miss_addr <= {imemaddr[WORD_W-1:2],2'b00}.
  - FILL: iREN = 1, iaddr = miss_addr, ihit = 0, imemload = 0.
  - FILL -> LOOKUP: when iwait == 0. On that edge, write the frame at miss_addr's index: valid = 1, tag = miss_addr's tag, data = iload.
- Latency:
  - Hit: 0 cycles (same cycle as the request).
  - Miss: 1 cycle to enter FILL, plus N cycles of iwait high, plus 1 lookup cycle. The re-lookup hits.
- Simultaneous and boundary events:
  - imemaddr changes or imemREN drops during FILL (branch/jump): the fill still completes for miss_addr. The lookup then repeats on the current imemaddr.
  - halt asserted during FILL: abort next edge to LOOKUP with no frame write. iREN drops that edge.
  - halt in LOOKUP: ihit = 0, no transition.
  - Conflict: addresses with equal idx but different tag evict each other; no replacement choice.
  - iwait low on the first FILL cycle: single-cycle fill is legal.
  - iaddr = 0 whenever not in FILL.
- Reset (including mid-FILL):
  - State -> LOOKUP, all valid <= 0, miss_addr <= 0; any in-flight fill is abandoned.
  - Output values under reset: ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
  - Tag/data arrays need not be reset.
- iload is sampled only on the fill-completing edge.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count (32 bits each, reset 0, saturating at 0xFFFFFFFF).
  - hit_count increments on each cycle with ihit = 1.
  - miss_count increments on each LOOKUP->FILL transition.
  - An aborted fill still counts as a miss.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_types_pkg (existing) supplies word_t.
- Add to it:
  - icache_state_t enum {LOOKUP, FILL}.
  - Frame struct icache_frame_t {valid, tag, data}.
  - Constant ICACHE_SETS = 16.
- One natural sub-module, icache_frames:
  - SETS-entry frame array.
  - Combinational read port on idx.
  - Synchronous write port.
  - Synchronous clear-valids on RST.
- The FSM and counters stay in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: after RST, imemREN=1, imemaddr=0x00000000; iwait high for 2 cycles then low, iload=0x8C010004.
  - Response: iREN high 3 cycles with iaddr=0x0; ihit=1 and imemload=0x8C010004 on the following cycle.
- Hit reuse:
  - Stimulus: refetch 0x00000000.
  - Response: ihit=1 same cycle, iREN stays 0.
  - Stimulus: 0x00000002.
  - Response: also hits (byte bits ignored).
- Conflict eviction (SETS=16):
  - Stimulus: fill 0x00000004 (data 0x11111111), then 0x00000044 (data 0x22222222), then 0x00000004 again.
  - Response: 0x44 misses and evicts; the final 0x04 misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x00000010, switch imemaddr to 0x00000020 while iwait is high.
  - Response: iaddr stays 0x10 until the fill completes; frame 4 becomes valid; 0x20 then misses with iaddr=0x20.
- Halt/reset mid-fill:
  - Stimulus: halt during FILL.
  - Response: next cycle iREN=0, no frame written; a later refetch misses.
  - Stimulus: RST during FILL.
  - Response: iREN=0, and every previously filled address misses afterwards.
- With ICACHE_STATS_EN:
  - Stimulus: run the cold-miss plus 3 hits.
  - Response: miss_count=1, hit_count=4 (includes the post-fill hit).
